// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch stage sitting after the PC register.
//
// Issues one outstanding read at a time to the instruction ROM. Each
// returned word is buffered together with its byte address in a small FIFO
// and is offered to decode through a valid/ready handshake. While a request
// is outstanding, or while the FIFO is full, the PC stage is held with
// stall_o. A taken jump (flush_i) empties the FIFO. Any read still in flight
// is marked so that its data is dropped when it returns.
//
// Ports:
//   clk, rstn          clock (rising edge) and asynchronous active-low reset
//   pc_addr_i          byte address from the PC stage
//   stall_o            PC stage must hold pc_addr_i this cycle
//   flush_i            taken jump; kill buffered and in-flight fetches
//   rom_req_o          one-cycle ROM read request
//   rom_addr_o         ROM word address (pc_addr_i without the byte offset)
//   rom_rvalid_i       ROM read data valid
//   rom_rdata_i        ROM read data
//   instr_valid_o      FIFO head valid toward decode
//   instr_ready_i      decode accepts the head entry
//   instr_o            instruction at the FIFO head
//   instr_addr_o       byte address of instr_o
module ifu_fetch #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              rom_req_o,
    output logic [ADDR_W-3:0] rom_addr_o,
    input  logic              rom_rvalid_i,
    input  logic [31:0]       rom_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_addr_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     count_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [31:0]       instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];

    logic issue;
    logic push;
    logic pop;

    // The full check uses only the registered count.
    // A pop in the same cycle does not free a slot for the issue decision.
    assign issue = (state_reg == IDLE) && (count_reg < DEPTH_C) && !flush_i;

    // During reset the FSM already reads as IDLE.
    // Both handshake outputs are gated with rstn so that they stay low in reset.
    assign rom_req_o  = rstn & issue;
    assign stall_o    = rstn & ~issue;
    assign rom_addr_o = pc_addr_i[ADDR_W-1:2];

    // Flush takes priority over both push and pop.
    assign push = (state_reg == WAIT) && rom_rvalid_i && !flush_i;
    assign pop  = instr_valid_o && instr_ready_i && !flush_i;

    assign instr_valid_o = (count_reg != '0);
    assign instr_o       = instr_mem[rd_ptr_reg];
    assign instr_addr_o  = addr_mem[rd_ptr_reg];

    // Fetch FSM.
    // The address is latched on issue, because the PC stage may move on
    // before the data returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            addr_q    <= '0;
        end else begin
            if (issue) begin
                addr_q <= pc_addr_i;
            end
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (rom_rvalid_i) begin
                        state_reg <= IDLE;
                    end else if (flush_i) begin
                        state_reg <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (rom_rvalid_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (flush_i) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage.
    // A request is issued only when a slot is free, so a push can never
    // overwrite the head entry while decode is stalling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem[i] <= '0;
                addr_mem[i]  <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr_reg] <= rom_rdata_i;
            addr_mem[wr_ptr_reg]  <= addr_q;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch.
// A queue-based reference model predicts the request, stall and FIFO-head
// outputs on every cycle. A small ROM responder returns a deterministic word
// for each word address. Directed scenarios are pinned with literal
// expectations, and a long randomized run follows them.
module tb_ifu_fetch;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rstn;
    logic [ADDR_W-1:0] pc_addr_i;
    logic              stall_o;
    logic              flush_i;
    logic              rom_req_o;
    logic [ADDR_W-3:0] rom_addr_o;
    logic              rom_rvalid_i;
    logic [31:0]       rom_rdata_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_addr_o;

    ifu_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc_addr_i    (pc_addr_i),
        .stall_o      (stall_o),
        .flush_i      (flush_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Reference model state: buffered entries plus the one pending request.
    ent_t       q[$];
    bit         busy;
    bit         kill;
    logic [9:0] pend_addr;

    // ROM responder state.
    int         rom_cnt;
    logic [7:0] rom_idx;
    int         lat_cfg;
    bit         stray;

    // DUT outputs sampled in the current cycle.
    logic        s_req, s_stall, s_valid;
    logic [7:0]  s_raddr;
    logic [31:0] s_instr;
    logic [9:0]  s_iaddr;

    logic [9:0]  cur_pc;

    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        return 32'h9E3779B9 * (32'(idx) + 32'd1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle. Drive the inputs on the falling edge, compare the DUT
    // against the model, then advance the model on the rising edge.
    task automatic step(input logic fl, input logic rdy, input logic [9:0] pc);
        logic exp_req;
        logic exp_valid;
        logic do_pop;
        @(negedge clk);
        flush_i       = fl;
        instr_ready_i = rdy;
        pc_addr_i     = pc;
        rom_rvalid_i  = 1'b0;
        rom_rdata_i   = $urandom;
        if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin
                rom_rvalid_i = 1'b1;
                rom_rdata_i  = rom_word(rom_idx);
            end
        end
        if (stray) begin
            rom_rvalid_i = 1'b1;
            stray        = 1'b0;
        end
        #1;
        s_req   = rom_req_o;
        s_stall = stall_o;
        s_valid = instr_valid_o;
        s_raddr = rom_addr_o;
        s_instr = instr_o;
        s_iaddr = instr_addr_o;
        exp_req   = !busy && (q.size() < DEPTH) && !fl;
        exp_valid = (q.size() != 0);
        chk("rom_req", 32'(s_req), 32'(exp_req));
        chk("stall", 32'(s_stall), 32'(!exp_req));
        if (exp_req) chk("rom_addr", 32'(s_raddr), 32'(pc[9:2]));
        chk("instr_valid", 32'(s_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("instr", s_instr, q[0].d);
            chk("instr_addr", 32'(s_iaddr), 32'(q[0].a));
        end
        @(posedge clk);
        do_pop = exp_valid && rdy && !fl;
        if (do_pop) begin
            $display("pop addr=%03h instr=%08h", q[0].a, q[0].d);
            void'(q.pop_front());
        end
        if (busy && rom_rvalid_i) begin
            if (!kill && !fl) q.push_back('{pend_addr, rom_word(pend_addr[9:2])});
            busy = 1'b0;
            kill = 1'b0;
        end else if (busy && fl) begin
            kill = 1'b1;
        end
        if (fl) q.delete();
        if (exp_req) begin
            busy      = 1'b1;
            kill      = 1'b0;
            pend_addr = pc;
        end
        if (s_req) begin
            rom_idx = s_raddr;
            rom_cnt = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 4);
        end
    endtask

    // Asserts reset in the middle of a cycle and checks that the outputs clear
    // at once. flush_i is held high across the release, so the DUT and the
    // model both leave reset idle.
    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_req", 32'(rom_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_iaddr", 32'(instr_addr_o), 32'd0);
        q.delete();
        busy = 1'b0;
        kill = 1'b0;
        rom_cnt = 0;
        rom_rvalid_i = 1'b0;
        flush_i = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; flush_i = 1'b1; instr_ready_i = 1'b0; pc_addr_i = '0;
        rom_rvalid_i = 1'b0; rom_rdata_i = '0;
        busy = 0; kill = 0; pend_addr = '0; rom_cnt = 0; rom_idx = '0; stray = 0;
        lat_cfg = 1;

        // Back-to-back fetch with a 1-cycle ROM and decode always ready.
        do_reset();
        cur_pc = 10'h000;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, cur_pc);
            if (i % 2 == 0) begin
                chk("t1_req", 32'(s_req), 32'd1);
                chk("t1_raddr", 32'(s_raddr), 32'(i / 2));
                if (i >= 2) begin
                    chk("t1_valid", 32'(s_valid), 32'd1);
                    chk("t1_iaddr", 32'(s_iaddr), 32'((i / 2 - 1) * 4));
                end
            end else begin
                chk("t1_stall", 32'(s_stall), 32'd1);
                chk("t1_novalid", 32'(s_valid), 32'd0);
            end
            if (i == 2) chk("t1_instr0", s_instr, 32'h9E3779B9);
            if (!s_stall) cur_pc = cur_pc + 10'd4;
        end

        // Decode stalled: the FIFO fills, then one pop frees a slot.
        do_reset();
        cur_pc = 10'h010;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i == 6), cur_pc);
            if (i == 4 || i == 5) begin
                chk("t2_stall", 32'(s_stall), 32'd1);
                chk("t2_noreq", 32'(s_req), 32'd0);
                chk("t2_head", 32'(s_iaddr), 32'h010);
            end
            if (i == 6) chk("t2_fullstall", 32'(s_stall), 32'd1);
            if (i == 7) begin
                chk("t2_req", 32'(s_req), 32'd1);
                chk("t2_raddr", 32'(s_raddr), 32'h006);
                chk("t2_head2", 32'(s_iaddr), 32'h014);
            end
            if (!s_stall) cur_pc = cur_pc + 10'd4;
        end

        // Flush while a 3-cycle read is in flight; the jump target follows.
        do_reset();
        lat_cfg = 3;
        for (int i = 0; i < 9; i++) begin
            step((i == 1), 1'b1, (i == 0) ? 10'h020 : 10'h100);
            if (i >= 1 && i <= 3) chk("t3_stall", 32'(s_stall), 32'd1);
            if (i >= 1 && i <= 7) chk("t3_novalid", 32'(s_valid), 32'd0);
            if (i == 4) begin
                chk("t3_req", 32'(s_req), 32'd1);
                chk("t3_raddr", 32'(s_raddr), 32'h040);
            end
            if (i == 8) begin
                chk("t3_valid", 32'(s_valid), 32'd1);
                chk("t3_iaddr", 32'(s_iaddr), 32'h100);
            end
        end

        // Flush in the same cycle as the returning data, with one entry
        // buffered and decode ready.
        do_reset();
        lat_cfg = 2;
        cur_pc = 10'h040;
        for (int i = 0; i < 7; i++) begin
            step((i == 5), (i == 5), cur_pc);
            if (i == 5) begin
                chk("t4_valid", 32'(s_valid), 32'd1);
                chk("t4_head", 32'(s_iaddr), 32'h040);
            end
            if (i == 6) begin
                chk("t4_empty", 32'(s_valid), 32'd0);
                chk("t4_req", 32'(s_req), 32'd1);
                chk("t4_raddr", 32'(s_raddr), 32'h012);
            end
            if (!s_stall) cur_pc = cur_pc + 10'd4;
        end

        // Asynchronous reset while a read is outstanding, then a stray rvalid.
        do_reset();
        lat_cfg = 3;
        cur_pc = 10'h080;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, cur_pc);
            if (!s_stall) cur_pc = cur_pc + 10'd4;
        end
        chk("t5_prevalid", 32'(s_valid), 32'd1);
        do_reset();
        lat_cfg = 1;
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 10'h000);
            if (i == 0) begin
                chk("t5_req", 32'(s_req), 32'd1);
                chk("t5_raddr", 32'(s_raddr), 32'd0);
                chk("t5_novalid", 32'(s_valid), 32'd0);
            end
            if (i == 2) begin
                chk("t5_valid", 32'(s_valid), 32'd1);
                chk("t5_iaddr", 32'(s_iaddr), 32'd0);
            end
        end

        // Push and pop in the same cycle at count 1.
        do_reset();
        cur_pc = 10'h200;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i == 3), cur_pc);
            if (i == 3) chk("t6_head", 32'(s_iaddr), 32'h200);
            if (i == 4) begin
                chk("t6_valid", 32'(s_valid), 32'd1);
                chk("t6_head2", 32'(s_iaddr), 32'h204);
                chk("t6_req", 32'(s_req), 32'd1);
            end
            if (!s_stall) cur_pc = cur_pc + 10'd4;
        end

        // Randomized traffic: variable ROM latency, jumps and mid-run resets.
        do_reset();
        lat_cfg = 0;
        cur_pc = 10'($urandom) & 10'h3FC;
        for (int n = 0; n < 4000; n++) begin
            logic fl;
            logic rdy;
            fl  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (fl) cur_pc = 10'($urandom);
            step(fl, rdy, cur_pc);
            if (!s_stall) cur_pc = cur_pc + 10'd4;
            if (n % 997 == 500) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
